// File: rtl/debounce_pkg.sv
// Shared types and defaults for the pushbutton debouncer.
// The optional press counter is enabled by BUTTON_DEBOUNCE_PRESS_COUNT_EN
// (see button_debounce.sv).
package debounce_pkg;

   // Roughly 2 ms at 120 MHz: long enough to ride out mechanical bounce.
   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 240000;

   typedef enum logic {
      STABLE   = 1'b0,
      COUNTING = 1'b1
   } state_t;

endpackage

// File: rtl/button_debounce_sync2.sv
// Two-flop synchronizer for a single asynchronous bit. The reset value is a
// parameter so the flops can idle at the input's inactive level.
module sync2 #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Two-stage capture of the async input; reset loads the idle level into both stages.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/button_debounce.sv
// Pushbutton debouncer: synchronizes a bouncy pin, accepts a level change only
// after DEBOUNCE_CYCLES consecutive samples at the new level, and emits
// one-cycle press/release pulses.
// Optional feature: define BUTTON_DEBOUNCE_PRESS_COUNT_EN to add an 8-bit
// wrapping press_count output.
module button_debounce
   import debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_raw,
   output logic       btn_level,
   output logic       btn_press,
   output logic       btn_release
`ifdef BUTTON_DEBOUNCE_PRESS_COUNT_EN
   ,
   output logic [7:0] press_count
`endif
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          w_sync;
   logic          w_s;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_level;
   logic          w_level_nxt;
   logic          r_press;
   logic          w_press_nxt;
   logic          r_release;
   logic          w_release_nxt;

   // Synchronizer idles at the inactive raw level so reset release looks "not pressed".
   sync2 #(
      .RESET_VAL (ACTIVE_LOW)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (btn_raw),
      .o_q (w_sync)
   );

   // Normalize so that 1 always means pressed.
   assign w_s = w_sync ^ ACTIVE_LOW;

   // State, counter, debounced level and pulse registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= STABLE;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_level   <= w_level_nxt;
         r_press   <= w_press_nxt;
         r_release <= w_release_nxt;
      end
   end

   // Next-state logic: count consecutive differing samples, any agreeing sample cancels.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_level_nxt   = r_level;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      case (r_state)
         STABLE: begin
            w_cnt_nxt = '0;
            if (w_s != r_level) begin
               w_state_nxt = COUNTING;
               w_cnt_nxt   = CW'(1);
            end
         end
         COUNTING: begin
            if (w_s == r_level) begin
               w_state_nxt = STABLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == LAST) begin
               w_level_nxt   = w_s;
               w_press_nxt   = w_s;
               w_release_nxt = ~w_s;
               w_state_nxt   = STABLE;
               w_cnt_nxt     = '0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_nxt = STABLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign btn_level   = r_level;
   assign btn_press   = r_press;
   assign btn_release = r_release;

`ifdef BUTTON_DEBOUNCE_PRESS_COUNT_EN
   logic [7:0] r_press_count;

   // Counts cycles on which the press pulse is high; wraps 255 -> 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_press_count <= '0;
      end else if (r_press) begin
         r_press_count <= r_press_count + 8'd1;
      end
   end

   assign press_count = r_press_count;
`endif

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 240000, consecutive stable synchronized samples required to accept a change (minimum 2).
REQ-002 SHALL have parameter ACTIVE_LOW, default 1; 1 means a raw input of 0 is "pressed".
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low (asserted when 0).
REQ-005 SHALL have port btn_raw, input, 1 bit: asynchronous, bouncy pushbutton pin.
REQ-006 SHALL have port btn_level, output, 1 bit: debounced state, 1 = pressed; drives the LED counter stage's run/clear input.
REQ-007 SHALL have port btn_press, output, 1 bit: one-cycle pulse on an accepted press.
REQ-008 SHALL have port btn_release, output, 1 bit: one-cycle pulse on an accepted release.
REQ-009 SHALL have port press_count, output, 8 bits, present only with BUTTON_DEBOUNCE_PRESS_COUNT_EN: number of accepted presses.

Function
REQ-010 SHALL pass btn_raw through a 2-flop synchronizer; s = second-flop output, normalized so s = 1 means pressed (inverted when ACTIVE_LOW = 1).
REQ-011 SHALL implement a 2-state FSM: STABLE and COUNTING.
REQ-012 In STABLE: if s equals btn_level, remain and hold cnt = 0; otherwise go to COUNTING with cnt <= 1.
REQ-013 In COUNTING: if s equals btn_level (bounce), go to STABLE with cnt <= 0 and no output change.
REQ-014 In COUNTING: if s differs and cnt < DEBOUNCE_CYCLES-1, cnt <= cnt+1.
REQ-015 In COUNTING: if s differs and cnt == DEBOUNCE_CYCLES-1, btn_level <= s, assert the matching pulse, go to STABLE, cnt <= 0.
REQ-016 Latency: with btn_raw changed before edge 1 and held, btn_level SHALL update at edge DEBOUNCE_CYCLES+2.
REQ-017 btn_press SHALL be registered and high for exactly the one cycle after btn_level goes 0->1; btn_release likewise for 1->0; they are never high together.
REQ-018 cnt width SHALL be $clog2(DEBOUNCE_CYCLES), and cnt SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap).
REQ-019 A glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no change on any output.

Reset
REQ-020 While rst = 0 at a clock edge: btn_level = 0, btn_press = 0, btn_release = 0, press_count = 0, state = STABLE, cnt = 0.
REQ-021 While rst = 0, both synchronizer flops SHALL load the inactive raw level (1 if ACTIVE_LOW, else 0), so no spurious press follows reset release.
REQ-022 Reset during COUNTING SHALL abandon the pending change with no pulse.
REQ-023 After release with btn_raw held pressed, a press SHALL be accepted after the normal REQ-016 latency.

Configuration
REQ-024 Macro BUTTON_DEBOUNCE_PRESS_COUNT_EN defined: press_count SHALL exist and increment on each cycle btn_press = 1, wrapping 255 -> 0.
REQ-025 Macro BUTTON_DEBOUNCE_PRESS_COUNT_EN undefined: the press_count port and its register SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-026 Package debounce_pkg SHALL hold the FSM state enum (STABLE, COUNTING) and the default DEBOUNCE_CYCLES constant.
REQ-027 The synchronizer SHALL be a sub-module sync2 (1-bit, reset value as a parameter), instantiated once.

Verification (DEBOUNCE_CYCLES = 4, ACTIVE_LOW = 1)
REQ-028 Reset release with btn_raw = 1 held for 20 cycles -> btn_level = 0, no pulses, press_count = 0.
REQ-029 btn_raw 1->0 before edge 1 and held -> btn_level = 1 at edge 6; btn_press high for exactly one cycle; press_count = 1.
REQ-030 btn_raw low for 3 cycles, then high for 1, then low held -> no change until 4 consecutive low samples, then exactly one btn_press.
REQ-031 From pressed, btn_raw 0->1 and held -> btn_level = 0 at edge 6; btn_release is a single one-cycle pulse; press_count unchanged.
REQ-032 rst = 0 asserted mid-COUNTING (cnt = 2) -> all outputs 0, no pulse; after release with btn_raw still low, press accepted 6 edges later.
REQ-033 256 clean presses with the macro defined -> press_count wraps to 0; with the macro undefined, the build has no press_count port.
